// File: rtl/video_mono_tint_pipe.sv
// ---------------------------------------------------------------------------
// video_mono_tint_pipe
//
// Converts an RGB video stream into one of several monochrome "phosphor"
// tints (green, amber, B&W, red, blue, fuchsia, purple) or passes colour
// through. Three pixel-enabled register stages:
//   S1 : register raw pixel, timing and the mode that applies to this pixel
//   S2 : compute luma (optionally with afterglow persistence)
//   S3 : apply the tint and register the outputs
//
// The active mode only changes on a VSync rising edge (or on the first
// ce_pix after reset), so a mode request never tears a frame.
//
// Optional feature: define MONO_PERSIST_EN to add a phosphor afterglow
// register; monochrome modes then use persistent luma instead of raw luma.
//
// Ports:
//   clk_vid                 video clock
//   reset                   synchronous, active-high
//   ce_pix                  pixel enable; every register advances only on it
//   gfx_mode[2:0]           requested mode (0 colour .. 7 purple)
//   R, G, B [DW-1:0]        source pixel
//   HSync, VSync, DE        source timing
//   R_OUT, G_OUT, B_OUT     converted pixel
//   HS_OUT, VS_OUT, DE_OUT  timing, delayed to match the pixel
// ---------------------------------------------------------------------------
module video_mono_tint_pipe #(
  parameter int DW          = 8,
  parameter int GREEN_FLOOR = 15,
  parameter int FLOOR       = 8,
  parameter int DECAY_SHIFT = 2
) (
  input  logic          clk_vid,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic [2:0]    gfx_mode,
  input  logic [DW-1:0] R,
  input  logic [DW-1:0] G,
  input  logic [DW-1:0] B,
  input  logic          HSync,
  input  logic          VSync,
  input  logic          DE,
  output logic [DW-1:0] R_OUT,
  output logic [DW-1:0] G_OUT,
  output logic [DW-1:0] B_OUT,
  output logic          HS_OUT,
  output logic          VS_OUT,
  output logic          DE_OUT
);

  localparam int LW = DW + 8;
  localparam logic [DW-1:0] FLOOR_V       = DW'(FLOOR);
  localparam logic [DW-1:0] GREEN_FLOOR_V = DW'(GREEN_FLOOR);
  localparam logic [DW-1:0] ONE_V         = DW'(1);

  // Mode tracking
  logic [2:0] active_mode;
  logic       load_pending;   // forces a mode load on the first ce_pix after reset
  logic       load_mode;
  logic [2:0] pixel_mode;

  // Stage 1
  logic [DW-1:0] r1, g1, b1;
  logic          hs1, vs1, de1;
  logic [2:0]    mode1;

  // Stage 2
  logic [DW-1:0] r2, g2, b2, p2;
  logic          hs2, vs2, de2;
  logic [2:0]    mode2;

  // Luma / persistence
  logic [LW-1:0] y_sum;
  logic [DW-1:0] y_s1;
  logic [DW-1:0] p_s1;

  // Stage 3 combinational result
  logic [DW-1:0] h3, f_floor3, f_green3;
  logic [DW-1:0] r3_nxt, g3_nxt, b3_nxt;

  // The pixel sampled on the VSync rise already uses the new mode, hence the
  // bypass of gfx_mode straight into mode1.
  assign load_mode  = load_pending || (!vs1 && VSync);
  assign pixel_mode = load_mode ? gfx_mode : active_mode;

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      active_mode  <= 3'd0;
      load_pending <= 1'b1;
      r1 <= '0; g1 <= '0; b1 <= '0;
      hs1 <= 1'b0; vs1 <= 1'b0; de1 <= 1'b0;
      mode1 <= 3'd0;
    end else if (ce_pix) begin
      active_mode  <= pixel_mode;
      load_pending <= 1'b0;
      r1 <= R; g1 <= G; b1 <= B;
      hs1 <= HSync; vs1 <= VSync; de1 <= DE;
      mode1 <= pixel_mode;
    end
  end

  // Weights sum to 256, so the shifted result always fits in DW bits.
  assign y_sum = LW'(54) * LW'(r1) + LW'(183) * LW'(g1) + LW'(19) * LW'(b1);
  assign y_s1  = y_sum[LW-1:8];

`ifdef MONO_PERSIST_EN
  logic [DW-1:0] glow;
  logic [DW-1:0] decay;

  assign decay = glow - (glow >> DECAY_SHIFT);
  assign p_s1  = (y_s1 > decay) ? y_s1 : decay;

  // Afterglow dies instantly outside the active area.
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      glow <= '0;
    end else if (ce_pix) begin
      glow <= de1 ? p_s1 : '0;
    end
  end
`else
  assign p_s1 = y_s1;
`endif

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      r2 <= '0; g2 <= '0; b2 <= '0; p2 <= '0;
      hs2 <= 1'b0; vs2 <= 1'b0; de2 <= 1'b0;
      mode2 <= 3'd0;
    end else if (ce_pix) begin
      r2 <= r1; g2 <= g1; b2 <= b1; p2 <= p_s1;
      hs2 <= hs1; vs2 <= vs1; de2 <= de1;
      mode2 <= mode1;
    end
  end

  assign h3       = p2 >> 1;
  assign f_floor3 = (p2 > FLOOR_V)       ? p2 : FLOOR_V;
  assign f_green3 = (p2 > GREEN_FLOOR_V) ? p2 : GREEN_FLOOR_V;

  always_comb begin
    r3_nxt = r2;
    g3_nxt = g2;
    b3_nxt = b2;
    case (mode2)
      3'd1: begin r3_nxt = '0;       g3_nxt = f_green3; b3_nxt = ONE_V;    end
      3'd2: begin r3_nxt = f_floor3; g3_nxt = h3;       b3_nxt = ONE_V;    end
      3'd3: begin r3_nxt = p2;       g3_nxt = p2;       b3_nxt = p2;       end
      3'd4: begin r3_nxt = f_floor3; g3_nxt = '0;       b3_nxt = ONE_V;    end
      3'd5: begin r3_nxt = '0;       g3_nxt = h3;       b3_nxt = f_floor3; end
      3'd6: begin r3_nxt = f_floor3; g3_nxt = '0;       b3_nxt = h3;       end
      3'd7: begin r3_nxt = h3;       g3_nxt = '0;       b3_nxt = f_floor3; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      R_OUT <= '0; G_OUT <= '0; B_OUT <= '0;
      HS_OUT <= 1'b0; VS_OUT <= 1'b0; DE_OUT <= 1'b0;
    end else if (ce_pix) begin
      R_OUT <= r3_nxt; G_OUT <= g3_nxt; B_OUT <= b3_nxt;
      HS_OUT <= hs2; VS_OUT <= vs2; DE_OUT <= de2;
    end
  end

endmodule

// File: doc/video_mono_tint_pipe.md
VIDEO_MONO_TINT_PIPE -- requirements
Module: video_mono_tint_pipe

Interface
REQ-001 SHALL have parameter DW, default 8: bits per colour channel, input and output.
REQ-002 SHALL have parameter GREEN_FLOOR, default 15: minimum luma in green mode.
REQ-003 SHALL have parameter FLOOR, default 8: minimum luma in amber, red, blue, fuchsia and purple modes.
REQ-004 SHALL have parameter DECAY_SHIFT, default 2: afterglow decay shift; used only when MONO_PERSIST_EN is defined.
REQ-005 SHALL have port clk_vid, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port ce_pix, input, 1 bit: pixel enable; all state advances only when it is high.
REQ-008 SHALL have port gfx_mode, input, 3 bits: requested mode (0 colour, 1 green, 2 amber, 3 B&W, 4 red, 5 blue, 6 fuchsia, 7 purple).
REQ-009 SHALL have ports R, G, B, input, DW bits each: source pixel.
REQ-010 SHALL have ports HSync, VSync, DE, input, 1 bit each: source timing.
REQ-011 SHALL have ports R_OUT, G_OUT, B_OUT, output, DW bits each: converted pixel.
REQ-012 SHALL have ports HS_OUT, VS_OUT, DE_OUT, output, 1 bit each: timing delayed to align with the pixel.

Function
REQ-013 SHALL be a 3-stage pipeline: S1 registers inputs, S2 computes luma, S3 applies the mode; each stage advances only on ce_pix.
REQ-014 SHALL present output for the input sampled on ce_pix edge N at ce_pix edge N+3; when ce_pix is low, all registers hold.
REQ-015 SHALL delay HSync, VSync and DE by exactly 3 ce_pix edges, aligned with the pixel data.
REQ-016 SHALL compute luma Y = (54*R + 183*G + 19*B) >> 8 with DW+8-bit intermediates, so Y never exceeds 2^DW-1.
REQ-017 SHALL define half luma H = Y >> 1 and floored luma F(x) = max(Y, x).
REQ-018 SHALL produce outputs {R_OUT, G_OUT, B_OUT} per active mode:
- 0 colour: {R, G, B}, delayed
- 1 green: {0, F(GREEN_FLOOR), 1}
- 2 amber: {F(FLOOR), H, 1}
- 3 B&W: {Y, Y, Y}
- 4 red: {F(FLOOR), 0, 1}
- 5 blue: {0, H, F(FLOOR)}
- 6 fuchsia: {F(FLOOR), 0, H}
- 7 purple: {H, 0, F(FLOOR)}
REQ-019 SHALL hold the active mode in a register separate from gfx_mode; changes to gfx_mode SHALL NOT affect output mid-frame.
REQ-020 SHALL load gfx_mode into the active mode on a ce_pix edge where the S1-registered VSync is 0 and the raw VSync is 1 (rising edge).
REQ-021 SHALL apply the new mode starting from the pixel sampled on that rising edge.
REQ-022 SHALL use only the last gfx_mode value sampled at the VSync rise; changes between rises are discarded.
REQ-023 SHALL load gfx_mode into the active mode on the first ce_pix after reset deasserts, regardless of VSync.

Reset
REQ-024 SHALL clear, on reset=1 at a clk_vid edge (ce_pix ignored): all pipeline data, R_OUT/G_OUT/B_OUT, HS_OUT/VS_OUT/DE_OUT, active mode (to 0) and afterglow state.
REQ-025 SHALL discard any in-flight pixels on reset mid-line; the first valid output appears 3 ce_pix edges after reset deasserts.

Configuration
REQ-026 SHALL, with MONO_PERSIST_EN defined, replace Y in modes 1-7 with persistent luma P computed in S2:
- P = max(Y, Gl - (Gl >> DECAY_SHIFT)), where Gl is the afterglow register
- Gl <= P on each ce_pix edge
- Gl <= 0 on any ce_pix edge where S1 DE = 0
REQ-027 SHALL, without MONO_PERSIST_EN, contain no afterglow register, making P identical to Y.

Verification
REQ-028 SHALL pass: DW=8, mode 3, RGB=FF,FF,FF on one ce_pix -> 3 ce_pix later RGB_OUT=FF,FF,FF, DE_OUT aligned; ce_pix held low for 5 clocks -> outputs unchanged.
REQ-029 SHALL pass: mode 2, RGB=FF,00,00 -> R_OUT=35, G_OUT=1A, B_OUT=01; mode 1, RGB=00,00,00 -> 00,0F,01.
REQ-030 SHALL pass: gfx_mode changed 3->1 mid-frame -> output remains B&W until the pixel sampled at the next VSync rise, which is green.
REQ-031 SHALL pass: gfx_mode toggles 1->4->5 within one frame -> mode 5 is applied at the next VSync rise.
REQ-032 SHALL pass: MONO_PERSIST_EN defined, DECAY_SHIFT=2, mode 3, DE=1, one FF pixel then 00 pixels -> Y_OUT=FF, C0, 90, 6C; DE=0 then a 00 pixel -> 00.
REQ-033 SHALL pass: reset asserted mid-line with valid pixels in flight -> all outputs 00 the next clock, active mode 0; after release, gfx_mode is loaded on the first ce_pix.
